// File: rtl/core_mul_issue.sv
// Execute-stage issue port for RV32M multiplies: drives the a/b/op streams to the
// multiplier, collects the r stream and hands the result to writeback.
module core_mul_issue #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [31:0] int_mul_a_tdata,
  output logic        int_mul_a_tvalid,
  input  logic        int_mul_a_tready,
  output logic [31:0] int_mul_b_tdata,
  output logic        int_mul_b_tvalid,
  input  logic        int_mul_b_tready,
  output logic [1:0]  int_mul_op_tdata,
  output logic        int_mul_op_tvalid,
  input  logic        int_mul_op_tready,
  input  logic [31:0] int_mul_r_tdata,
  input  logic        int_mul_r_tvalid,
  output logic        int_mul_r_tready,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [6:0] WDOG_LAST = 7'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] WDOG_MAX  = 7'(TIMEOUT_CYCLES);

  logic [1:0]  r_state;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [1:0]  r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_wb_data;
  logic        r_drop;
  logic        r_tvalid;
  logic        r_wb_valid;
  logic        r_err;
  logic [6:0]  r_wdog;

  logic w_req_fire;
  logic w_issue_fire;
  logic w_r_fire;

  // A flush in IDLE blocks acceptance so a squashed instruction never enters.
  assign req_ready    = RST_N && (r_state == S_IDLE) && !flush;
  assign w_req_fire   = req_valid && req_ready;
  // Issue only completes when all three streams handshake in the same cycle.
  assign w_issue_fire = r_tvalid && int_mul_a_tready && int_mul_b_tready
                        && int_mul_op_tready;
  assign w_r_fire     = int_mul_r_tvalid && int_mul_r_tready;

  assign int_mul_a_tdata   = r_rs1;
  assign int_mul_b_tdata   = r_rs2;
  assign int_mul_op_tdata  = r_op;
  assign int_mul_a_tvalid  = r_tvalid;
  assign int_mul_b_tvalid  = r_tvalid;
  assign int_mul_op_tvalid = r_tvalid;
  assign int_mul_r_tready  = (r_state == S_WAIT);
  assign wb_valid          = r_wb_valid;
  assign wb_rd             = r_rd;
  assign wb_data           = r_wb_data;
  assign busy              = (r_state != S_IDLE);
  assign err_timeout       = r_err;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_wb_data  <= '0;
      r_drop     <= 1'b0;
      r_tvalid   <= 1'b0;
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      r_wdog     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_rs1  <= req_rs1;
            r_rs2  <= req_rs2;
            r_op   <= req_funct3[1:0];
            r_rd   <= req_rd;
            r_drop <= 1'b0;
            if (req_funct3[2]) begin
              r_wb_data  <= '0;
              r_wb_valid <= 1'b1;
              r_state    <= S_WB;
            end else begin
              r_tvalid <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (flush) r_drop <= 1'b1;
          if (w_issue_fire) begin
            r_tvalid <= 1'b0;
            r_wdog   <= '0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_r_fire) begin
            // A result for a flushed op is still drained so the unit is left empty.
            if (r_drop || flush) begin
              r_state <= S_IDLE;
            end else begin
              r_wb_data  <= int_mul_r_tdata;
              r_wb_valid <= 1'b1;
              r_state    <= S_WB;
            end
          end else begin
            if (flush) r_drop <= 1'b1;
            if (r_wdog != WDOG_MAX) r_wdog <= r_wdog + 7'd1;
            if (r_wdog == WDOG_LAST) r_err <= 1'b1;
          end
        end
        S_WB: begin
          if (wb_ready || flush) begin
            r_wb_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mul_issue.sv
// Scoreboard bench for core_mul_issue: the bench plays requester, multiplier and
// writeback consumer; a monitor checks every issue and writeback against queues.
module tb_core_mul_issue;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_ready, flush;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic [31:0] int_mul_a_tdata, int_mul_b_tdata, int_mul_r_tdata;
  logic [1:0]  int_mul_op_tdata;
  logic        int_mul_a_tvalid, int_mul_b_tvalid, int_mul_op_tvalid;
  logic        int_mul_a_tready, int_mul_b_tready, int_mul_op_tready;
  logic        int_mul_r_tvalid, int_mul_r_tready;
  logic        wb_valid, wb_ready, busy, err_timeout;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  core_mul_issue #(.TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .int_mul_a_tdata(int_mul_a_tdata), .int_mul_a_tvalid(int_mul_a_tvalid),
    .int_mul_a_tready(int_mul_a_tready),
    .int_mul_b_tdata(int_mul_b_tdata), .int_mul_b_tvalid(int_mul_b_tvalid),
    .int_mul_b_tready(int_mul_b_tready),
    .int_mul_op_tdata(int_mul_op_tdata), .int_mul_op_tvalid(int_mul_op_tvalid),
    .int_mul_op_tready(int_mul_op_tready),
    .int_mul_r_tdata(int_mul_r_tdata), .int_mul_r_tvalid(int_mul_r_tvalid),
    .int_mul_r_tready(int_mul_r_tready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] op; } iss_t;
  wb_t  wb_q[$];
  iss_t iss_q[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // RV32M result from the architectural definition using 64-bit products.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] ex, ey, p;
    ex = (f3[1:0] == 2'b11) ? {32'd0, x} : {{32{x[31]}}, x};
    ey = (f3[1:0] == 2'b01) ? {{32{y[31]}}, y} : {32'd0, y};
    p  = ex * ey;
    if (f3[2]) return 32'd0;
    return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: pops expectations on every issue / writeback handshake.
  logic        p_iss, p_wb, jt;
  logic [31:0] pa, pb, pwd;
  logic [1:0]  pop;
  logic [4:0]  prd;
  iss_t        ei;
  wb_t         ew;

  initial begin
    p_iss = 1'b0;
    p_wb  = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST_N !== 1'b1) begin
        p_iss = 1'b0;
        p_wb  = 1'b0;
      end else begin
        jt = (int_mul_a_tvalid && int_mul_b_tvalid && int_mul_op_tvalid &&
              int_mul_a_tready && int_mul_b_tready && int_mul_op_tready) === 1'b1;
        if (p_iss)
          check("issue_hold",
                {int_mul_a_tvalid, int_mul_b_tvalid, int_mul_op_tvalid,
                 int_mul_a_tdata, int_mul_b_tdata, int_mul_op_tdata},
                {3'b111, pa, pb, pop});
        if (p_wb)
          check("wb_hold", {wb_valid, wb_rd, wb_data}, {1'b1, prd, pwd});
        if (jt) begin
          if (iss_q.size() == 0) check("issue_unexpected", iss_q.size(), 1);
          else begin
            ei = iss_q.pop_front();
            check("issue_data", {int_mul_a_tdata, int_mul_b_tdata, int_mul_op_tdata},
                  {ei.a, ei.b, ei.op});
          end
        end
        if ((wb_valid && wb_ready) === 1'b1) begin
          if (wb_q.size() == 0) check("wb_unexpected", wb_q.size(), 1);
          else begin
            ew = wb_q.pop_front();
            check("wb_result", {wb_rd, wb_data}, {ew.rd, ew.data});
          end
        end
        p_iss = ((int_mul_a_tvalid || int_mul_b_tvalid || int_mul_op_tvalid) === 1'b1) && !jt;
        p_wb  = (wb_valid === 1'b1) && (wb_ready !== 1'b1) && (flush !== 1'b1);
        pa = int_mul_a_tdata; pb = int_mul_b_tdata; pop = int_mul_op_tdata;
        prd = wb_rd; pwd = wb_data;
      end
    end
  end

  task automatic set_rdy(input int rpat, input int c);
    logic [2:0] r;
    case (rpat)
      0: r = 3'b111;
      1: case (c)
           0: r = 3'b100; 1: r = 3'b010; 2: r = 3'b001;
           3: r = 3'b000; 4: r = 3'b110; default: r = 3'b111;
         endcase
      default: r = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0};
    endcase
    {int_mul_a_tready, int_mul_b_tready, int_mul_op_tready} = r;
  endtask

  // fmode: 0 none, 1 flush in ISSUE, 2 flush 3 cycles into WAIT,
  // 3 flush with the r handshake, 4 flush in WB. Entered and left at posedge+1.
  task automatic txn(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] rd, input int rpat, input int rdly,
                     input int wbdly, input int fmode);
    int n;
    logic hs;
    logic [31:0] ca, cb;
    logic [1:0] cop;
    wb_t w;
    iss_t s;
    ca = '0; cb = '0; cop = '0;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = x; req_rs2 = y; req_rd = rd;
    n = 0;
    do begin @(negedge CLK); hs = req_ready; n++; end while (!hs && n < 200);
    if (!hs) check("req_wait", hs, 1);
    if (fmode == 0) begin w.rd = rd; w.data = ref_res(f3, x, y); wb_q.push_back(w); end
    if (!f3[2]) begin s.a = x; s.b = y; s.op = f3[1:0]; iss_q.push_back(s); end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    if (!f3[2]) begin
      for (int c = 0; c < 100; c++) begin
        set_rdy(rpat, c);
        flush = (fmode == 1 && c == 0);
        @(negedge CLK);
        if (c == 0 || rpat == 1)
          check("tvalid_high", {int_mul_a_tvalid, int_mul_b_tvalid, int_mul_op_tvalid}, 3'b111);
        hs = int_mul_a_tvalid && int_mul_b_tvalid && int_mul_op_tvalid &&
             int_mul_a_tready && int_mul_b_tready && int_mul_op_tready;
        if (rpat == 1 && c < 5) check("stagger_no_issue", hs, 0);
        ca = int_mul_a_tdata; cb = int_mul_b_tdata; cop = int_mul_op_tdata;
        @(posedge CLK); #1;
        flush = 1'b0;
        if (hs) break;
        if (c == 99) check("issue_wait", hs, 1);
      end
      {int_mul_a_tready, int_mul_b_tready, int_mul_op_tready} = 3'b111;
      for (int c = 0; c < 300; c++) begin
        flush = (fmode == 2 && c == 3) || (fmode == 3 && c == rdly);
        int_mul_r_tvalid = (c >= rdly);
        int_mul_r_tdata  = ref_res({1'b0, cop}, ca, cb);
        @(negedge CLK);
        hs = int_mul_r_tvalid && int_mul_r_tready;
        @(posedge CLK); #1;
        flush = 1'b0;
        if (hs) break;
        if (c == 299) check("r_wait", hs, 1);
      end
      int_mul_r_tvalid = 1'b0;
      if (fmode >= 1 && fmode <= 3) begin
        @(negedge CLK);
        check("flushed_no_wb", {wb_valid, busy}, 2'b00);
        @(posedge CLK); #1;
        return;
      end
    end
    if (fmode == 4) begin
      for (int c = 0; c <= wbdly; c++) begin
        flush = (c == wbdly);
        @(negedge CLK);
        check("wb_valid_pre_flush", wb_valid, 1);
        @(posedge CLK); #1;
        flush = 1'b0;
      end
      @(negedge CLK);
      check("wb_flushed", {wb_valid, busy}, 2'b00);
      @(posedge CLK); #1;
      return;
    end
    for (int c = 0; c < 300; c++) begin
      wb_ready = (c >= wbdly);
      @(negedge CLK);
      check("wb_valid", wb_valid, 1);
      if (c == 0 && f3[2])
        check("nonmul_no_issue", {int_mul_a_tvalid, int_mul_b_tvalid, int_mul_op_tvalid}, 3'b000);
      if (c < wbdly) check("req_ready_in_wb", req_ready, 0);
      hs = wb_valid && wb_ready;
      @(posedge CLK); #1;
      wb_ready = 1'b0;
      if (hs) break;
    end
    @(negedge CLK);
    check("ready_after_wb", {req_ready, busy}, 2'b10);
    @(posedge CLK); #1;
  endtask

  task automatic timeout_test();
    iss_t s;
    req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd3; req_rs2 = 32'd4; req_rd = 5'd1;
    s.a = 32'd3; s.b = 32'd4; s.op = 2'b00; iss_q.push_back(s);
    @(negedge CLK);
    check("to_req_ready", req_ready, 1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    check("to_issue", int_mul_a_tvalid, 1);
    @(posedge CLK); #1;
    for (int k = 0; k < 70; k++) begin
      @(negedge CLK);
      if (k == 0) check("to_r_tready", int_mul_r_tready, 1);
      if (k == 63) check("wdog_early", err_timeout, 0);
      if (k == 64 || k == 69) check("wdog_set", err_timeout, 1);
    end
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(negedge CLK);
    check("rst_mid_req_ready", req_ready, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_mid_ctrl",
          {busy, err_timeout, int_mul_r_tready, int_mul_a_tvalid, wb_valid, req_ready},
          6'b000001);
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [2:0] f3;
    int fm, rd;
    RST_N = 1'b0; req_valid = 1'b0; flush = 1'b0; req_funct3 = '0;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    int_mul_a_tready = 1'b1; int_mul_b_tready = 1'b1; int_mul_op_tready = 1'b1;
    int_mul_r_tvalid = 1'b0; int_mul_r_tdata = '0; wb_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", req_ready, 0);
    check("rst_ctrl", {busy, int_mul_a_tvalid, int_mul_b_tvalid, int_mul_op_tvalid,
                       int_mul_r_tready, wb_valid, err_timeout}, 7'd0);
    check("rst_data", {wb_data, wb_rd, int_mul_a_tdata, int_mul_b_tdata, int_mul_op_tdata}, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", req_ready, 1);
    @(posedge CLK); #1;

    txn(3'b000, 32'd7, 32'd6, 5'd5, 0, 2, 0, 0);
    txn(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 0, 1, 0, 0);
    txn(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 0, 0, 1, 0);
    txn(3'b010, 32'hFFFFFFFF, 32'd2, 5'd3, 0, 3, 0, 0);
    txn(3'b000, 32'h12345678, 32'h9ABCDEF0, 5'd9, 1, 2, 0, 0);
    txn(3'b011, 32'hDEADBEEF, 32'h0BADF00D, 5'd10, 0, 1, 10, 0);
    txn(3'b001, 32'h80000000, 32'h7FFFFFFF, 5'd11, 0, 6, 0, 2);
    txn(3'b100, 32'h11111111, 32'h22222222, 5'd12, 0, 0, 1, 0);
    txn(3'b010, 32'h80000001, 32'hFFFFFFFF, 5'd13, 0, 2, 0, 1);
    txn(3'b000, 32'h00000003, 32'h00000005, 5'd14, 0, 2, 0, 3);
    txn(3'b001, 32'hCAFEBABE, 32'h13572468, 5'd15, 0, 1, 2, 4);
    txn(3'b110, 32'h5, 32'h6, 5'd16, 0, 0, 1, 4);

    req_valid = 1'b1; req_funct3 = 3'b000; flush = 1'b1;
    @(negedge CLK);
    check("flush_idle_ready", req_ready, 0);
    @(posedge CLK); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge CLK);
    check("flush_idle_busy", busy, 0);
    @(posedge CLK); #1;

    for (int i = 0; i < 40; i++) begin
      f3 = {($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3))};
      fm = $urandom_range(0, 7);
      fm = (fm < 4) ? 0 : fm - 3;
      if (f3[2] && fm != 4) fm = 0;
      rd = $urandom_range(0, 31);
      txn(f3, $urandom, $urandom, 5'(rd), 2,
          (fm == 2) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 6)),
          $urandom_range(0, 3), fm);
    end

    timeout_test();
    txn(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 0, 1, 0, 0);

    repeat (3) @(negedge CLK);
    check("wb_q_drained", wb_q.size(), 0);
    check("iss_q_drained", iss_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=%0d", total, 0);
    $fatal(1, "timeout");
  end

endmodule
